// File: rtl/lin_collision_resolver.sv
// LIN event-triggered collision resolver: walks the collision table
// and issues one header request per associated frame ID.
module lin_collision_resolver #(
  parameter int CNT_W   = 4,
  parameter int TMO_CYC = 4096,
  parameter int TMO_W   = 13
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic             et_valid,
  input  logic             et_collision,
  input  logic [31:0]      et_base,
  input  logic [CNT_W-1:0] et_cnt,
  input  logic             abort,
  output logic [31:0]      tbl_addr,
  input  logic [31:0]      tbl_data,
  output logic             hdr_req,
  output logic [5:0]       hdr_id,
  input  logic             hdr_ack,
  input  logic             frm_done,
  output logic             busy,
  output logic             res_done,
  output logic             res_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_REQ,
    S_WAIT,
    S_NEXT,
    S_DONE
  } state_t;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

  state_t           state_q, state_d;
  logic [31:0]      base_q, base_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] idx_inc;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [5:0]       id_q, id_d;
  logic             err_q, err_d;
  logic             ent_bad;
  logic             tmo_hit;

  assign idx_inc  = idx_q + CNT_W'(1);
  assign tbl_addr = base_q + 32'(idx_q);
  assign ent_bad  = (tbl_data[31:6] != '0) ||
                    (tbl_data[5:0] > 6'h3B);
  assign tmo_hit  = (tmo_q == TMO_LAST);

  assign hdr_req  = (state_q == S_REQ);
  assign hdr_id   = id_q;
  assign busy     = (state_q != S_IDLE);
  assign res_done = (state_q == S_DONE);
  assign res_err  = err_q;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;
    id_d    = id_q;
    err_d   = err_q;
    // Abort wins over all walk activity; DONE always drains to IDLE.
    if (abort && state_q != S_IDLE &&
        state_q != S_DONE) begin
      state_d = S_DONE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (!abort && et_valid && et_collision) begin
            if (et_cnt != '0) begin
              state_d = S_LOOKUP;
              base_d  = et_base;
              cnt_d   = et_cnt;
              idx_d   = '0;
              err_d   = 1'b0;
            end else begin
              state_d = S_DONE;
            end
          end
        end
        S_LOOKUP: begin
          id_d = tbl_data[5:0];
          if (ent_bad) begin
            err_d   = 1'b1;
            state_d = S_NEXT;
          end else begin
            state_d = S_REQ;
          end
        end
        S_REQ: begin
          if (hdr_ack) begin
            tmo_d   = '0;
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          tmo_d = tmo_q + TMO_W'(1);
          if (frm_done) begin
            state_d = S_NEXT;
          end else if (tmo_hit) begin
            err_d   = 1'b1;
            state_d = S_NEXT;
          end
        end
        S_NEXT: begin
          idx_d   = idx_inc;
          state_d = (idx_inc == cnt_q) ? S_DONE
                                       : S_LOOKUP;
        end
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      tmo_q   <= '0;
      id_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      id_q    <= id_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_lin_collision_resolver.sv
// Bench for lin_collision_resolver: vector table plus hand-built
// timeout, abort and reset sequences with a frame-engine model.
module tb_lin_collision_resolver;

  localparam int TMO = 4096;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        et_valid = 1'b0;
  logic        et_collision = 1'b0;
  logic [31:0] et_base = '0;
  logic [3:0]  et_cnt = '0;
  logic        abort = 1'b0;
  logic [31:0] tbl_addr;
  logic [31:0] tbl_data;
  logic        hdr_req;
  logic [5:0]  hdr_id;
  logic        hdr_ack = 1'b0;
  logic        frm_done = 1'b0;
  logic        busy;
  logic        res_done;
  logic        res_err;

  logic [31:0] mem [64];
  logic [5:0]  sb [$];
  int n_cmp = 0;
  int n_bad = 0;
  int fe_ph = 0;
  int ack_cnt = 0;
  int dn_cnt = 0;
  int ack_dly = 0;
  int done_dly = 0;
  int done_seen = 0;
  int req_seen = 0;

  lin_collision_resolver #(
    .CNT_W(4), .TMO_CYC(TMO), .TMO_W(13)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .et_valid(et_valid),
    .et_collision(et_collision),
    .et_base(et_base), .et_cnt(et_cnt),
    .abort(abort), .tbl_addr(tbl_addr),
    .tbl_data(tbl_data), .hdr_req(hdr_req),
    .hdr_id(hdr_id), .hdr_ack(hdr_ack),
    .frm_done(frm_done), .busy(busy),
    .res_done(res_done), .res_err(res_err)
  );

  always #5 PCLK = ~PCLK;

  assign tbl_data = mem[tbl_addr[5:0]];

  // Frame-engine model and monitor; runs on the falling edge.
  always @(negedge PCLK) begin
    logic [5:0] exp_id;
    hdr_ack  = 1'b0;
    frm_done = 1'b0;
    if (!PRESETn) begin
      fe_ph   = 0;
      ack_cnt = 0;
      dn_cnt  = 0;
    end else begin
      if (res_done) done_seen++;
      if (hdr_req) req_seen++;
      if (fe_ph == 1 && (!busy || hdr_req)) fe_ph = 0;
      if (fe_ph == 0) begin
        if (!hdr_req) begin
          ack_cnt = 0;
        end else if (ack_cnt < ack_dly) begin
          ack_cnt++;
        end else begin
          hdr_ack = 1'b1;
          fe_ph   = 1;
          ack_cnt = 0;
          dn_cnt  = 0;
          n_cmp++;
          if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL hdr_id: got %h, none expected",
                     hdr_id);
          end else begin
            exp_id = sb.pop_front();
            if (hdr_id !== exp_id) begin
              n_bad++;
              $display("FAIL hdr_id: got %h want %h",
                       hdr_id, exp_id);
            end
          end
        end
      end else if (dn_cnt < done_dly) begin
        dn_cnt++;
      end else begin
        frm_done = 1'b1;
        fe_ph    = 0;
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic fire(input logic coll,
                      input logic [3:0] cnt,
                      input logic [31:0] base);
    step();
    et_valid     = 1'b1;
    et_collision = coll;
    et_cnt       = cnt;
    et_base      = base;
    step();
    et_valid     = 1'b0;
    et_collision = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int k;
    k = 0;
    while (busy && k < lim) begin
      step();
      k++;
    end
    chk("idle_timeout", busy, 1'b0);
  endtask

  typedef struct {
    logic        coll;
    logic [3:0]  cnt;
    logic [31:0] base;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [31:0] e2;
    int          n;
    logic [5:0]  x0;
    logic [5:0]  x1;
    logic [5:0]  x2;
    logic        err;
    int          dn;
  } vec_t;

  vec_t v [7];

  initial begin
    int d0;
    int r0;
    int k;

    foreach (mem[i]) mem[i] = '0;
    v[0] = '{1'b1, 4'd2, 32'h0, 32'h25, 32'h26, 32'h0,
             2, 6'h25, 6'h26, 6'h00, 1'b0, 1};
    v[1] = '{1'b0, 4'd2, 32'h0, 32'h25, 32'h26, 32'h0,
             0, 6'h00, 6'h00, 6'h00, 1'b0, 0};
    v[2] = '{1'b1, 4'd2, 32'h10, 32'h25, 32'h3C, 32'h0,
             1, 6'h25, 6'h00, 6'h00, 1'b1, 1};
    v[3] = '{1'b1, 4'd0, 32'h0, 32'h0, 32'h0, 32'h0,
             0, 6'h00, 6'h00, 6'h00, 1'b1, 1};
    v[4] = '{1'b1, 4'd1, 32'h20, 32'h3B, 32'h0, 32'h0,
             1, 6'h3B, 6'h00, 6'h00, 1'b0, 1};
    v[5] = '{1'b1, 4'd3, 32'hFFFF_FFFF, 32'h01, 32'h40,
             32'h02, 2, 6'h01, 6'h02, 6'h00, 1'b1, 1};
    v[6] = '{1'b1, 4'd3, 32'h30, 32'h00, 32'h3F,
             32'h8000_0005, 1, 6'h00, 6'h00, 6'h00,
             1'b1, 1};

    repeat (3) step();
    chk("rst_addr", tbl_addr, 32'h0);
    chk("rst_req", hdr_req, 1'b0);
    chk("rst_id", hdr_id, 6'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", res_done, 1'b0);
    chk("rst_err", res_err, 1'b0);
    PRESETn = 1'b1;
    step();

    for (int i = 0; i < 7; i++) begin
      mem[6'(v[i].base)]         = v[i].e0;
      mem[6'(v[i].base + 32'd1)] = v[i].e1;
      mem[6'(v[i].base + 32'd2)] = v[i].e2;
      if (v[i].n > 0) sb.push_back(v[i].x0);
      if (v[i].n > 1) sb.push_back(v[i].x1);
      if (v[i].n > 2) sb.push_back(v[i].x2);
      ack_dly  = i % 3;
      done_dly = i % 4;
      d0 = done_seen;
      r0 = req_seen;
      fire(v[i].coll, v[i].cnt, v[i].base);
      chk($sformatf("v%0d_busy", i), busy, v[i].coll);
      wait_idle(200);
      step();
      chk($sformatf("v%0d_dones", i), done_seen - d0, v[i].dn);
      chk($sformatf("v%0d_err", i), res_err, v[i].err);
      chk($sformatf("v%0d_left", i), sb.size(), 0);
      if (v[i].n == 0)
        chk($sformatf("v%0d_noreq", i), req_seen - r0, 0);
    end

    // Every frame overruns: one cycle past the last allowed cycle.
    mem[6'h04] = 32'h25;
    mem[6'h05] = 32'h26;
    sb.push_back(6'h25);
    sb.push_back(6'h26);
    ack_dly  = 0;
    done_dly = TMO;
    d0 = done_seen;
    fire(1'b1, 4'd2, 32'h44);
    wait_idle(3 * TMO);
    step();
    chk("tmo_err", res_err, 1'b1);
    chk("tmo_dones", done_seen - d0, 1);
    chk("tmo_left", sb.size(), 0);

    // frm_done on the very last cycle still counts as done.
    mem[6'h08] = 32'h25;
    sb.push_back(6'h25);
    done_dly = TMO - 1;
    d0 = done_seen;
    fire(1'b1, 4'd1, 32'h48);
    chk("edge_clr", res_err, 1'b0);
    wait_idle(2 * TMO);
    step();
    chk("edge_err", res_err, 1'b0);
    chk("edge_dones", done_seen - d0, 1);
    chk("edge_left", sb.size(), 0);

    // Abort while waiting for the first frame.
    mem[6'h10] = 32'h25;
    mem[6'h11] = 32'h26;
    sb.push_back(6'h25);
    ack_dly  = 0;
    done_dly = 100;
    d0 = done_seen;
    fire(1'b1, 4'd2, 32'h50);
    k = 0;
    while (!hdr_ack && k < 50) begin
      step();
      k++;
    end
    chk("abt_ack", hdr_ack, 1'b1);
    repeat (3) step();
    abort = 1'b1;
    step();
    chk("abt_done", res_done, 1'b1);
    chk("abt_req", hdr_req, 1'b0);
    et_valid     = 1'b1;
    et_collision = 1'b1;
    et_cnt       = 4'd1;
    et_base      = 32'h50;
    step();
    step();
    et_valid     = 1'b0;
    et_collision = 1'b0;
    chk("abt_block", busy, 1'b0);
    abort = 1'b0;
    repeat (3) step();
    chk("abt_idle", busy, 1'b0);
    chk("abt_dones", done_seen - d0, 1);
    chk("abt_left", sb.size(), 0);

    // Reset pulse while a header request is pending.
    mem[6'h20] = 32'h25;
    sb.push_back(6'h25);
    ack_dly = 50;
    d0 = done_seen;
    fire(1'b1, 4'd1, 32'h60);
    k = 0;
    while (!hdr_req && k < 20) begin
      step();
      k++;
    end
    chk("rst_mid_req", hdr_req, 1'b1);
    #2;
    PRESETn = 1'b0;
    #1;
    chk("rst_mid_req0", hdr_req, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_id", hdr_id, 6'h0);
    step();
    PRESETn = 1'b1;
    sb.delete();
    repeat (10) step();
    chk("rst_mid_dones", done_seen - d0, 0);
    chk("rst_mid_idle", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
